pong_vblank_ctrl: RTL and testbench

- iomem slave that double-buffers the pong object positions (left/right paddle, ball x/y) and commits them to the renderer only at the start of vertical blanking, so no frame shows torn positions.
- Decodes its own iomem address page and supplies the live position outputs to the pong renderer.
- Provides a frame counter and a maskable vblank interrupt so firmware can pace its game loop.

---
 rtl/pong_vblank_ctrl.sv | 158 +++++++++++++++
 tb/tb_pong_vblank_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_vblank_ctrl.sv
// iomem slave holding double-buffered pong positions. Shadow values are copied to the
// renderer outputs only at the start of vertical blanking, so no frame shows torn positions.
module pong_vblank_ctrl #(
  parameter logic [7:0] BASE     = 8'h0C,
  parameter int         V_ACTIVE = 480,
  parameter int         POS_W    = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [9:0]       y,
  output logic [POS_W-1:0] paddle_left_pos,
  output logic [POS_W-1:0] paddle_right_pos,
  output logic [POS_W-1:0] ball_pos_x,
  output logic [POS_W-1:0] ball_pos_y,
  output logic             irq_vblank
);

  localparam logic [9:0] V_START = 10'(V_ACTIVE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [POS_W-1:0] shadow [4];
  logic [15:0]      frame_cnt;
  logic             vblank_flag;
  logic             irq_en;
  logic             vblank_d;

  logic             sel;
  logic             wr;
  logic             ctrl_wr;
  logic             commit_wr;
  logic             vb;
  logic             vb_edge;
  logic [2:0]       off;
  logic [31:0]      rd_mux;

  function automatic logic [31:0] ext_pos(input logic [POS_W-1:0] v);
    return {{(32-POS_W){1'b0}}, v};
  endfunction

  // Bus decode and vblank rising-edge detect.
  always_comb begin
    sel       = iomem_valid & ~iomem_ready & (iomem_addr[31:24] == BASE);
    off       = iomem_addr[4:2];
    wr        = sel & (iomem_wstrb != 4'b0000);
    ctrl_wr   = wr & (off == 3'd4) & iomem_wstrb[0];
    commit_wr = ctrl_wr & iomem_wdata[0];
    vb        = (y >= V_START);
    vb_edge   = vb & ~vblank_d;
  end

  // Commit sequencer next state; the edge wins over a same-cycle arm while IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (commit_wr) state_nxt = ARMED;
        else           state_nxt = IDLE;
      end
      ARMED: begin
        if (vb_edge) state_nxt = COMMIT;
        else         state_nxt = ARMED;
      end
      COMMIT: begin
        if (commit_wr) state_nxt = ARMED;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Commit sequencer state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Shadow position registers, byte-lane writable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
    end else if (wr && (off[2] == 1'b0)) begin
      if (iomem_wstrb[0]) shadow[off[1:0]][7:0]       <= iomem_wdata[7:0];
      if (iomem_wstrb[1]) shadow[off[1:0]][POS_W-1:8] <= iomem_wdata[POS_W-1:8];
    end
  end

  // Live renderer outputs take the shadows as they stood at the start of COMMIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      paddle_left_pos  <= '0;
      paddle_right_pos <= '0;
      ball_pos_x       <= '0;
      ball_pos_y       <= '0;
    end else if (state == COMMIT) begin
      paddle_left_pos  <= shadow[0];
      paddle_right_pos <= shadow[1];
      ball_pos_x       <= shadow[2];
      ball_pos_y       <= shadow[3];
    end
  end

  // Frame counter, vblank flag (edge set beats W1C) and interrupt enable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vblank_d    <= 1'b1;
      frame_cnt   <= 16'd0;
      vblank_flag <= 1'b0;
      irq_en      <= 1'b0;
    end else begin
      vblank_d <= vb;
      if (vb_edge) frame_cnt <= frame_cnt + 16'd1;
      if (vb_edge)                        vblank_flag <= 1'b1;
      else if (ctrl_wr && iomem_wdata[2]) vblank_flag <= 1'b0;
      if (ctrl_wr) irq_en <= iomem_wdata[1];
    end
  end

  // Read data selection.
  always_comb begin
    rd_mux = 32'd0;
    case (off)
      3'd0:    rd_mux = ext_pos(shadow[0]);
      3'd1:    rd_mux = ext_pos(shadow[1]);
      3'd2:    rd_mux = ext_pos(shadow[2]);
      3'd3:    rd_mux = ext_pos(shadow[3]);
      3'd4:    rd_mux = {29'd0, vblank_flag, irq_en, (state != IDLE)};
      3'd5:    rd_mux = {16'd0, frame_cnt};
      default: rd_mux = 32'd0;
    endcase
  end

  // One-cycle acknowledge with registered read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'd0;
    end else begin
      iomem_ready <= sel;
      iomem_rdata <= sel ? rd_mux : 32'd0;
    end
  end

  assign irq_vblank = vblank_flag & irq_en;

endmodule

// File: tb/tb_pong_vblank_ctrl.sv
// Self-checking bench for pong_vblank_ctrl: directed corner cases plus random bus/frame
// traffic compared against a frame-level reference model.
module tb_pong_vblank_ctrl;

  localparam logic [7:0] PAGE = 8'h0C;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [9:0]  y;
  logic [9:0]  paddle_left_pos;
  logic [9:0]  paddle_right_pos;
  logic [9:0]  ball_pos_x;
  logic [9:0]  ball_pos_y;
  logic        irq_vblank;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [9:0]  m_sh [4];
  logic [9:0]  m_live [4];
  logic [15:0] m_fc;
  logic        m_flag;
  logic        m_irqen;
  logic        m_armed;

  pong_vblank_ctrl #(.BASE(8'h0C), .V_ACTIVE(480), .POS_W(10)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .iomem_valid      (iomem_valid),
    .iomem_ready      (iomem_ready),
    .iomem_wstrb      (iomem_wstrb),
    .iomem_addr       (iomem_addr),
    .iomem_wdata      (iomem_wdata),
    .iomem_rdata      (iomem_rdata),
    .y                (y),
    .paddle_left_pos  (paddle_left_pos),
    .paddle_right_pos (paddle_right_pos),
    .ball_pos_x       (ball_pos_x),
    .ball_pos_y       (ball_pos_y),
    .irq_vblank       (irq_vblank)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_sh[i]   = 10'd0;
      m_live[i] = 10'd0;
    end
    m_fc = 16'd0; m_flag = 1'b0; m_irqen = 1'b0; m_armed = 1'b0;
  endtask

  task automatic m_write(input logic [2:0] off, input logic [3:0] ws, input logic [31:0] wd);
    if (ws != 4'd0) begin
      if (off < 3'd4) begin
        if (ws[0]) m_sh[off[1:0]][7:0] = wd[7:0];
        if (ws[1]) m_sh[off[1:0]][9:8] = wd[9:8];
      end else if (off == 3'd4 && ws[0]) begin
        m_irqen = wd[1];
        if (wd[2]) m_flag = 1'b0;
        if (wd[0]) m_armed = 1'b1;
      end
    end
  endtask

  // one vblank start: counter, flag, and the pending commit if armed
  task automatic m_frame();
    m_fc   = m_fc + 16'd1;
    m_flag = 1'b1;
    if (m_armed) begin
      for (int i = 0; i < 4; i++) m_live[i] = m_sh[i];
      m_armed = 1'b0;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] off);
    if (off < 3'd4)  return {22'd0, m_sh[off[1:0]]};
    if (off == 3'd4) return {29'd0, m_flag, m_irqen, m_armed};
    if (off == 3'd5) return {16'd0, m_fc};
    return 32'd0;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_paddle_left"},  {22'd0, paddle_left_pos},  {22'd0, m_live[0]});
    check({tag, "_paddle_right"}, {22'd0, paddle_right_pos}, {22'd0, m_live[1]});
    check({tag, "_ball_x"},       {22'd0, ball_pos_x},       {22'd0, m_live[2]});
    check({tag, "_ball_y"},       {22'd0, ball_pos_y},       {22'd0, m_live[3]});
    check({tag, "_irq"},          {31'd0, irq_vblank},       {31'd0, m_flag & m_irqen});
  endtask

  task automatic bus_start(input logic [2:0] off, input logic [3:0] ws, input logic [31:0] wd);
    iomem_valid = 1'b1;
    iomem_addr  = {PAGE, 19'd0, off, 2'b00};
    iomem_wstrb = ws;
    iomem_wdata = wd;
  endtask

  task automatic bus_finish(output logic [31:0] rd);
    int lat;
    lat = 0;
    rd  = 32'd0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (iomem_ready) begin
        lat = i;
        rd  = iomem_rdata;
        break;
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'd0;
    check("ack_latency", lat, 1);
  endtask

  task automatic bus(input logic [2:0] off, input logic [3:0] ws, input logic [31:0] wd,
                     output logic [31:0] rd);
    @(negedge clk);
    bus_start(off, ws, wd);
    bus_finish(rd);
  endtask

  task automatic wr(input logic [2:0] off, input logic [3:0] ws, input logic [31:0] wd);
    logic [31:0] rd;
    bus(off, ws, wd, rd);
    m_write(off, ws, wd);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] off);
    logic [31:0] rd;
    logic [31:0] exp;
    exp = m_read(off);
    bus(off, 4'd0, 32'd0, rd);
    check(tag, rd, exp);
  endtask

  task automatic frame();
    @(negedge clk) y = 10'd479;
    @(negedge clk) y = 10'd480;
    repeat (3) @(negedge clk);
    y = 10'd0;
    @(negedge clk);
  endtask

  task automatic load_shadows(input logic [9:0] a, input logic [9:0] b,
                              input logic [9:0] c, input logic [9:0] d);
    wr(3'd0, 4'b1111, {22'd0, a});
    wr(3'd1, 4'b1111, {22'd0, b});
    wr(3'd2, 4'b1111, {22'd0, c});
    wr(3'd3, 4'b1111, {22'd0, d});
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] wd;
    logic [2:0]  off;
    logic [3:0]  ws;
    int          op;

    resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'd0;
    iomem_addr = 32'd0; iomem_wdata = 32'd0; y = 10'd0;
    m_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    check("reset_ready", {31'd0, iomem_ready}, 32'd0);
    check("reset_rdata", iomem_rdata, 32'd0);
    resetn = 1'b1;
    rd_chk("reset_frame_cnt", 3'd5);
    rd_chk("reset_ctrl", 3'd4);

    // shadow write without commit never reaches the renderer
    wr(3'd0, 4'b0011, 32'h0000_0123);
    rd_chk("shadow_readback", 3'd0);
    check("shadow_readback_const", m_read(3'd0), 32'h123);
    repeat (3) begin
      frame(); m_frame();
    end
    check_outputs("no_commit");

    // armed commit with two-cycle latency
    load_shadows(10'd150, 10'd150, 10'd120, 10'd240);
    wr(3'd4, 4'b1111, 32'd1);
    rd_chk("commit_pending", 3'd4);
    @(negedge clk) y = 10'd479;
    @(negedge clk) y = 10'd480;
    @(negedge clk);
    check_outputs("commit_plus1");
    @(negedge clk);
    m_frame();
    check_outputs("commit_plus2");
    check("commit_left_const", {22'd0, paddle_left_pos}, 32'd150);
    rd_chk("commit_done", 3'd4);
    y = 10'd0;
    @(negedge clk);

    // interrupt and frame counter
    wr(3'd4, 4'b1111, 32'b110);
    check_outputs("irq_cleared");
    frame(); m_frame();
    check_outputs("irq_set");
    rd_chk("frame_cnt_inc", 3'd5);
    wr(3'd4, 4'b1111, 32'b110);
    check_outputs("irq_w1c");
    @(negedge clk) y = 10'd479;
    @(negedge clk) y = 10'd480;
    bus_start(3'd4, 4'b1111, 32'b110);
    bus_finish(rd);
    m_write(3'd4, 4'b1111, 32'b110);
    m_frame();
    check_outputs("set_beats_clear");
    y = 10'd0;
    @(negedge clk);

    // counter wrap
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    m_fc = 16'hFFFF;
    frame(); m_frame();
    rd_chk("frame_cnt_wrap", 3'd5);

    // shadow write during COMMIT is held for the next commit
    load_shadows(10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
    wr(3'd4, 4'b1111, 32'd1);
    @(negedge clk) y = 10'd479;
    @(negedge clk) y = 10'd480;
    @(negedge clk);
    wd = $urandom;
    bus_start(3'd0, 4'b0011, wd);
    bus_finish(rd);
    m_frame();
    m_write(3'd0, 4'b0011, wd);
    check_outputs("write_in_commit");
    rd_chk("write_in_commit_shadow", 3'd0);
    y = 10'd0;

    // commit write during COMMIT re-arms for the next frame
    wr(3'd4, 4'b1111, 32'd1);
    @(negedge clk) y = 10'd479;
    @(negedge clk) y = 10'd480;
    @(negedge clk);
    bus_start(3'd4, 4'b0001, 32'd1);
    bus_finish(rd);
    m_frame();
    m_write(3'd4, 4'b0001, 32'd1);
    check_outputs("rearm_in_commit");
    rd_chk("rearm_status", 3'd4);
    y = 10'd0;
    load_shadows(10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
    frame(); m_frame();
    check_outputs("rearm_commits");

    // arming on the edge cycle while idle waits a full frame
    load_shadows(10'd11, 10'd22, 10'd33, 10'd44);
    @(negedge clk) y = 10'd480;
    bus_start(3'd4, 4'b1111, 32'd1);
    bus_finish(rd);
    m_frame();
    m_write(3'd4, 4'b1111, 32'd1);
    repeat (2) @(negedge clk);
    check_outputs("arm_on_edge");
    rd_chk("arm_on_edge_status", 3'd4);
    y = 10'd0;
    frame(); m_frame();
    check_outputs("arm_on_edge_next");

    // another page is ignored
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = 32'h0D00_0000; iomem_wstrb = 4'hF; iomem_wdata = $urandom;
    repeat (3) begin
      @(negedge clk);
      check("foreign_page_ready", {31'd0, iomem_ready}, 32'd0);
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'd0;
    rd_chk("foreign_page_shadow", 3'd0);

    // random traffic
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          off = 3'($urandom_range(0, 3)); ws = 4'($urandom_range(0, 15)); wd = $urandom;
          if (ws == 4'd0) rd_chk("rand_shadow_read", off);
          else            wr(off, ws, wd);
        end
        1: wr(3'd4, 4'b0001, 32'($urandom_range(0, 7)));
        2: rd_chk("rand_read", 3'($urandom_range(0, 7)));
        3: begin
          frame(); m_frame();
        end
        default: begin
          wr(3'($urandom_range(6, 7)), 4'hF, $urandom);
          rd_chk("rand_after_unused", 3'($urandom_range(0, 5)));
        end
      endcase
      check_outputs("rand");
    end

    // async reset drops ready mid-transaction
    @(negedge clk);
    bus_start(3'd5, 4'd0, 32'd0);
    @(posedge clk);
    #1;
    check("ready_before_reset", {31'd0, iomem_ready}, 32'd1);
    resetn = 1'b0;
    #1;
    check("ready_async_drop", {31'd0, iomem_ready}, 32'd0);
    iomem_valid = 1'b0;
    m_reset();
    @(negedge clk) resetn = 1'b1;

    // reset during the COMMIT cycle, released inside blanking
    load_shadows(10'd301, 10'd302, 10'd303, 10'd304);
    wr(3'd4, 4'b1111, 32'd1);
    frame(); m_frame();
    check_outputs("pre_reset_live");
    wr(3'd4, 4'b1111, 32'd1);
    @(negedge clk) y = 10'd479;
    @(negedge clk) y = 10'd480;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    m_reset();
    check_outputs("reset_in_commit");
    y = 10'd500;
    @(negedge clk) resetn = 1'b1;
    repeat (3) @(negedge clk);
    rd_chk("release_in_blank_cnt", 3'd5);
    rd_chk("release_in_blank_ctrl", 3'd4);
    check_outputs("release_in_blank");
    y = 10'd0;
    @(negedge clk);
    frame(); m_frame();
    rd_chk("first_frame_after_reset", 3'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
